// File: rtl/fsm_unit_scheduler.sv
// fsm_unit_scheduler: round-robin arbiter that shares one start/done compute unit between NUM_REQ requesters (req_*, rsp_*, unit_*, busy, grant_id)
module fsm_unit_scheduler #(
  parameter int NUM_REQ        = 4,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255,
  localparam int GRANT_W       = $clog2(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [NUM_REQ-1:0]            rsp_valid,
  output logic [DATA_WIDTH-1:0]         rsp_data,
  output logic                          rsp_timeout,
  output logic                          unit_start,
  output logic [DATA_WIDTH-1:0]         unit_arg,
  input  logic                          unit_done,
  input  logic [DATA_WIDTH-1:0]         unit_result,
  output logic                          busy,
  output logic [GRANT_W-1:0]            grant_id
);
  typedef enum logic [7:0] {IDLE, ISSUE, WAIT, RESPOND} state_t;
  state_t fsm_state, fsm_state_n;
  logic [GRANT_W-1:0] ptr, sel;
  logic [7:0] timer;
  logic any, timed_out;
  always_comb begin
    sel = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--)
      if (req_valid[(int'(ptr) + k) % NUM_REQ]) sel = GRANT_W'((int'(ptr) + k) % NUM_REQ);
  end
  assign any       = |req_valid;
  assign timed_out = (TIMEOUT_CYCLES != 0) && (timer == 8'(TIMEOUT_CYCLES));
  always_comb begin
    fsm_state_n = fsm_state;
    case (fsm_state)
      IDLE:    fsm_state_n = any ? ISSUE : IDLE;
      ISSUE:   fsm_state_n = WAIT;
      WAIT:    fsm_state_n = (unit_done || timed_out) ? RESPOND : WAIT;
      RESPOND: fsm_state_n = IDLE;
      default: fsm_state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      fsm_state   <= IDLE;
      ptr         <= '0;
      grant_id    <= '0;
      unit_arg    <= '0;
      rsp_data    <= '0;
      rsp_timeout <= 1'b0;
      timer       <= '0;
    end else begin
      fsm_state <= fsm_state_n;
      if (fsm_state == IDLE && any) begin
        grant_id <= sel;
        unit_arg <= req_data[int'(sel)*DATA_WIDTH +: DATA_WIDTH];
      end
      if (fsm_state == ISSUE) timer <= '0;
      if (fsm_state == WAIT) begin
        if (unit_done) begin
          rsp_data    <= unit_result;
          rsp_timeout <= 1'b0;
        end else if (timed_out) begin
          rsp_data    <= '0;
          rsp_timeout <= 1'b1;
        end else begin
          timer <= timer + 8'd1;
        end
      end
      if (fsm_state == RESPOND) ptr <= (grant_id == GRANT_W'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
    end
  end
  assign busy       = fsm_state != IDLE;
  assign unit_start = fsm_state == ISSUE;
  assign req_ready  = unit_start ? NUM_REQ'(1) << grant_id : '0;
  assign rsp_valid  = (fsm_state == RESPOND) ? NUM_REQ'(1) << grant_id : '0;
endmodule

// File: tb/tb_fsm_unit_scheduler.sv
// tb_fsm_unit_scheduler: job-level reference model driving fsm_unit_scheduler with directed and random jobs
module tb_fsm_unit_scheduler;
  localparam int N = 4, W = 32, TO = 5;
  logic clk = 0, reset = 1;
  logic [N-1:0] req_valid = '0, req_ready, rsp_valid;
  logic [N*W-1:0] req_data = '0;
  logic [W-1:0] rsp_data, unit_arg, unit_result = '0;
  logic rsp_timeout, unit_start, unit_done = 0, busy;
  logic [1:0] grant_id;
  int total = 0, bad = 0, mptr = 0;
  logic [W-1:0] last_d = '0;
  logic last_to = 0;
  logic [W-1:0] rd [N];
  fsm_unit_scheduler #(.NUM_REQ(N), .DATA_WIDTH(W), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_timeout(rsp_timeout), .unit_start(unit_start),
    .unit_arg(unit_arg), .unit_done(unit_done), .unit_result(unit_result), .busy(busy), .grant_id(grant_id)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic quiet(input string tag);
    chk({tag, "_rdy"}, req_ready, 0);
    chk({tag, "_rspv"}, rsp_valid, 0);
    chk({tag, "_start"}, unit_start, 0);
  endtask
  task automatic all_zero(input string tag);
    quiet(tag);
    chk({tag, "_rspd"}, rsp_data, 0);
    chk({tag, "_rspto"}, rsp_timeout, 0);
    chk({tag, "_arg"}, unit_arg, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_gid"}, grant_id, 0);
  endtask
  function automatic int pick(input logic [N-1:0] m);
    for (int k = 0; k < N; k++) if (m[(mptr + k) % N]) return (mptr + k) % N;
    return 0;
  endfunction
  task automatic do_reset;
    reset = 1;
    req_valid = '0;
    unit_done = 0;
    tick;
    reset = 0;
    all_zero("reset");
    mptr = 0;
    last_d = '0;
    last_to = 0;
  endtask
  task automatic gap(input int n);
    for (int i = 0; i < n; i++) begin
      req_valid = '0;
      unit_done = 1'($urandom_range(0, 1));
      unit_result = $urandom;
      chk("gap_busy", busy, 0);
      quiet("gap");
      chk("gap_hold_d", rsp_data, last_d);
      chk("gap_hold_to", rsp_timeout, last_to);
      tick;
    end
    unit_done = 0;
  endtask
  task automatic run_job(input logic [N-1:0] mask, input int d, input int rst_at);
    int g, rc;
    logic [W-1:0] arg, exp_d;
    logic exp_to;
    g = pick(mask);
    arg = rd[g];
    exp_to = !(d >= 1 && d <= TO + 1);
    rc = exp_to ? TO + 3 : 2 + d;
    exp_d = exp_to ? '0 : W'(arg + 7);
    for (int i = 0; i < N; i++) req_data[i*W +: W] = rd[i];
    req_valid = mask;
    unit_done = 1'($urandom_range(0, 1));
    unit_result = $urandom;
    chk("idle_busy", busy, 0);
    quiet("idle");
    tick;
    req_valid = N'($urandom);
    unit_done = 1'($urandom_range(0, 1));
    unit_result = $urandom;
    chk("issue_rdy", req_ready, 64'(1) << g);
    chk("issue_start", unit_start, 1);
    chk("issue_rspv", rsp_valid, 0);
    chk("grant", grant_id, g);
    chk("issue_arg", unit_arg, arg);
    for (int c = 2; c <= rc; c++) begin
      tick;
      if (c == rst_at) begin
        reset = 1;
        req_valid = '0;
        unit_done = 0;
        tick;
        reset = 0;
        all_zero("midrst");
        mptr = 0;
        last_d = '0;
        last_to = 0;
        tick;
        chk("midrst_rspv", rsp_valid, 0);
        chk("midrst_busy", busy, 0);
        return;
      end
      req_valid = N'($urandom);
      unit_done = (c == 1 + d);
      unit_result = W'(arg + 7);
      chk("hold_arg", unit_arg, arg);
      chk("job_busy", busy, 1);
      if (c < rc) quiet("wait");
      else begin
        chk("rsp_valid", rsp_valid, 64'(1) << g);
        chk("rsp_data", rsp_data, exp_d);
        chk("rsp_timeout", rsp_timeout, exp_to);
        chk("rsp_rdy", req_ready, 0);
        chk("rsp_start", unit_start, 0);
      end
    end
    unit_done = 0;
    req_valid = '0;
    mptr = (g + 1) % N;
    last_d = exp_d;
    last_to = exp_to;
    tick;
  endtask
  initial begin
    tick;
    do_reset;
    rd[2] = 32'h8;
    run_job(4'b0100, 3, 0);
    do_reset;
    for (int i = 0; i < N; i++) rd[i] = W'(32'h10 + i);
    repeat (5) run_job(4'hF, 1, 0);
    run_job(4'b1000, 1, 0);
    run_job(4'b1001, 2, 0);
    run_job(4'b0010, 0, 0);
    gap(3);
    rd[3] = 32'h23;
    run_job(4'b1000, TO + 1, 0);
    run_job(4'b0001, TO + 2, 0);
    gap(2);
    run_job(4'b0100, 0, 4);
    run_job(4'b1010, 1, 0);
    repeat (150) begin
      for (int i = 0; i < N; i++) rd[i] = $urandom;
      run_job(N'($urandom_range(1, 15)), $urandom_range(0, 7), 0);
      gap($urandom_range(0, 2));
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
